bus_arbiter: RTL and testbench
==============================

# bus_arbiter

Two-master arbiter sharing the single peripheral/DRAM bus in front of the address-decoding bridge. Master 0 is the CPU data port; master 1 is a second bus master (debug loader / DMA engine). Ownership is registered and handed over by a three-state FSM with round-robin tie-breaking and a bounded burst length, so neither master can starve the other. The owner's address, write-enable and write data drive the bridge; read data returns combinationally to the owner only.

## Interface
- MAX_BURST, 8: maximum consecutive granted accesses by one master while the other is requesting; legal range 1..256
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- m0_req  in  1  master 0 requests an access this cycle
- m0_addr  in  32  master 0 byte address
- m0_wen  in  1  master 0 write enable
- m0_wdata  in  32  master 0 write data
- m0_gnt  out  1  master 0 owns the bus this cycle
- m0_rdata  out  32  read data to master 0
- m1_req, m1_addr, m1_wen, m1_wdata, m1_gnt, m1_rdata: identical for master 1
- bus_addr  out  32  address to bridge
- bus_wen  out  1  write enable to bridge
- bus_wdata  out  32  write data to bridge
- bus_rdata  in  32  read data from bridge
- owner  out  2  one-hot current owner {m1,m0}; 00 = idle

## Operation
- Registers: state ∈ {IDLE, OWN0, OWN1}; last (last master served, 1 bit); burst_cnt, width clog2(MAX_BURST) (min 1).
- Grants decode from state only: m0_gnt = (state==OWN0), m1_gnt = (state==OWN1); owner = {m1_gnt, m0_gnt}.
- An access completes in any cycle where mX_gnt & mX_req.
- Bus mux: OWN0 → m0 signals, OWN1 → m1 signals; IDLE → bus_addr=0, bus_wdata=0, bus_wen=0.
- bus_wen = owner's wen & owner's req & ~rst. Non-owner wen never reaches the bus.
- mX_rdata = bus_rdata when mX_gnt, else 32'hFFFF_FFFF.
- IDLE: only m0_req → OWN0; only m1_req → OWN1; both → master ≠ last; neither → stay. burst_cnt ← 0.
- OWNx, owner req low: other requesting → OWN(other), else IDLE; last ← x; burst_cnt ← 0.
- OWNx, access completes, burst_cnt == MAX_BURST-1:
  - other requesting → OWN(other), last ← x, burst_cnt ← 0.
  - otherwise stay, burst_cnt ← 0.
- OWNx, access completes, below limit → stay, burst_cnt + 1.
- burst_cnt counts only while the other master is requesting; when the other's req is low it is held at 0.
- Direct OWN0↔OWN1 handover, no IDLE bubble.

## Timing
- Reset (rst high at an edge): state=IDLE, last=1 (m0 wins first tie), burst_cnt=0. After that edge: m0_gnt=m1_gnt=0, owner=00, bus_addr=bus_wdata=0, bus_wen=0, both rdata=FFFF_FFFF.
- While rst is high, bus_wen=0 even if state is still OWNx. A write presented during a reset cycle is dropped.
- Grant latency: req rising at cycle n from IDLE → gnt high in cycle n+1.
- A master's req must stay high with stable addr/wen/wdata until it samples its gnt high. Each gnt&req cycle is one access.
- Reads are zero-latency: bus_rdata is valid in the same cycle as the granted access.
- Writes commit at the rising edge ending the granted cycle.
- Handover: the last access of the old owner happens in cycle n; the new owner's gnt is high in cycle n+1.
- Simultaneous req drop by the owner and req rise by the other: handover occurs (the other sees gnt the next cycle).
- MAX_BURST=1 with both requesting gives strict alternation, one access each.
- Worst-case wait for a requesting master: MAX_BURST cycles plus 1.

## Test plan
- Reset, then no requests for 5 cycles → owner=00, bus_wen=0, bus_addr=0, m0_rdata=m1_rdata=FFFF_FFFF.
- Cycle 1: m0_req=1, addr=0x100, wen=1, wdata=0xDEADBEEF → m0_gnt=1 in cycle 2, bus_wen=1 and bus_addr=0x100 in cycle 2 only; m1 stays 0.
- m0 and m1 both rise from IDLE after reset → m0 granted first. Both hold req with MAX_BURST=8 → m0 gets exactly 8 accesses, m1 gnt in cycle 10, then m1 gets 8 accesses.
- m1 owns the bus; m0_wen=1 with m0_req=0 → bus_wen tracks m1 only. m1 read of 0xFFFFF000 with bus_rdata=0x12 → m1_rdata=0x12, m0_rdata=FFFF_FFFF.
- m0 owns mid-burst (burst_cnt=3) with a write pending; rst pulses 1 cycle → bus_wen=0 during the rst cycle, owner=00 after. m0 holds req → regranted 1 cycle after rst falls.
- m0 alone requests for 20 cycles → continuous gnt with no drop at count 8. m1 req then rises → m1 gnt within 9 cycles.

Source files
------------

// File: rtl/bus_arbiter.sv
// Two-master bus arbiter: registered ownership, round-robin tie-break,
// bounded bursts while the other master waits, owner-only bus/rdata muxing.
module bus_arbiter #(
    parameter int unsigned MAX_BURST = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req,
    input  logic [31:0] m0_addr,
    input  logic        m0_wen,
    input  logic [31:0] m0_wdata,
    output logic        m0_gnt,
    output logic [31:0] m0_rdata,
    input  logic        m1_req,
    input  logic [31:0] m1_addr,
    input  logic        m1_wen,
    input  logic [31:0] m1_wdata,
    output logic        m1_gnt,
    output logic [31:0] m1_rdata,
    output logic [31:0] bus_addr,
    output logic        bus_wen,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    output logic [1:0]  owner
);

    localparam int unsigned CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    state_t           state, state_nxt;
    logic             last, last_nxt;
    logic [CNT_W-1:0] burst_cnt, cnt_nxt;
    logic             own_req, oth_req;
    state_t           other;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            last      <= 1'b1;
            burst_cnt <= '0;
        end else begin
            state     <= state_nxt;
            last      <= last_nxt;
            burst_cnt <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        last_nxt  = last;
        cnt_nxt   = '0;
        own_req   = (state == OWN1) ? m1_req : m0_req;
        oth_req   = (state == OWN1) ? m0_req : m1_req;
        other     = (state == OWN0) ? OWN1 : OWN0;
        case (state)
            IDLE: begin
                if (m0_req && m1_req)
                    state_nxt = last ? OWN0 : OWN1;
                else if (m0_req)
                    state_nxt = OWN0;
                else if (m1_req)
                    state_nxt = OWN1;
            end
            OWN0, OWN1: begin
                if (!own_req) begin
                    last_nxt  = (state == OWN1);
                    state_nxt = oth_req ? other : IDLE;
                end else if (oth_req) begin
                    // The burst limit only matters while the other master is waiting.
                    if (burst_cnt == CNT_LAST) begin
                        last_nxt  = (state == OWN1);
                        state_nxt = other;
                    end else begin
                        cnt_nxt = burst_cnt + 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        m0_gnt    = (state == OWN0);
        m1_gnt    = (state == OWN1);
        owner     = {m1_gnt, m0_gnt};
        bus_addr  = '0;
        bus_wdata = '0;
        bus_wen   = 1'b0;
        if (m0_gnt) begin
            bus_addr  = m0_addr;
            bus_wdata = m0_wdata;
            bus_wen   = m0_wen & m0_req & ~rst;
        end else if (m1_gnt) begin
            bus_addr  = m1_addr;
            bus_wdata = m1_wdata;
            bus_wen   = m1_wen & m1_req & ~rst;
        end
        m0_rdata = m0_gnt ? bus_rdata : '1;
        m1_rdata = m1_gnt ? bus_rdata : '1;
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a behavioural ownership model.
module tb_bus_arbiter;

    localparam int MB = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m0_wen, m1_req, m1_wen;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata, bus_rdata;
    logic        m0_gnt, m1_gnt, bus_wen;
    logic [31:0] m0_rdata, m1_rdata, bus_addr, bus_wdata;
    logic [1:0]  owner;

    int errors = 0;
    int checks = 0;

    // Model: owning master (-1 idle), last served, accesses in current contested streak.
    int m_own;
    int m_last;
    int m_streak;

    always #5 clk = ~clk;

    bus_arbiter #(.MAX_BURST(MB)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_wen(m0_wen), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_wen(m1_wen), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rdata(m1_rdata),
        .bus_addr(bus_addr), .bus_wen(bus_wen), .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata), .owner(owner)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic req_of(input int x);
        return (x == 0) ? m0_req : m1_req;
    endfunction
    function automatic logic wen_of(input int x);
        return (x == 0) ? m0_wen : m1_wen;
    endfunction
    function automatic logic [31:0] addr_of(input int x);
        return (x == 0) ? m0_addr : m1_addr;
    endfunction
    function automatic logic [31:0] wdata_of(input int x);
        return (x == 0) ? m0_wdata : m1_wdata;
    endfunction

    task automatic compare_model();
        logic [31:0] ea, ew;
        logic        ewen;
        ea = 32'h0; ew = 32'h0; ewen = 1'b0;
        if (m_own >= 0) begin
            ea   = addr_of(m_own);
            ew   = wdata_of(m_own);
            ewen = wen_of(m_own) & req_of(m_own) & ~rst;
        end
        chk("m0_gnt", m0_gnt, m_own == 0);
        chk("m1_gnt", m1_gnt, m_own == 1);
        chk("owner", owner, {m_own == 1, m_own == 0});
        chk("bus_addr", bus_addr, ea);
        chk("bus_wdata", bus_wdata, ew);
        chk("bus_wen", bus_wen, ewen);
        chk("m0_rdata", m0_rdata, (m_own == 0) ? bus_rdata : 32'hFFFF_FFFF);
        chk("m1_rdata", m1_rdata, (m_own == 1) ? bus_rdata : 32'hFFFF_FFFF);
    endtask

    task automatic model_step();
        int x, y;
        if (rst) begin
            m_own = -1; m_last = 1; m_streak = 0;
        end else if (m_own < 0) begin
            m_streak = 0;
            if (m0_req && m1_req) m_own = 1 - m_last;
            else if (m0_req)      m_own = 0;
            else if (m1_req)      m_own = 1;
        end else begin
            x = m_own;
            y = 1 - x;
            if (!req_of(x)) begin
                m_last   = x;
                m_own    = req_of(y) ? y : -1;
                m_streak = 0;
            end else if (req_of(y)) begin
                m_streak++;
                if (m_streak == MB) begin
                    m_last = x; m_own = y; m_streak = 0;
                end
            end else begin
                m_streak = 0;
            end
        end
    endtask

    task automatic sample();
        @(negedge clk);
        compare_model();
    endtask

    task automatic advance();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic cycle();
        sample();
        advance();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    task automatic idle_inputs();
        m0_req = 1'b0; m0_wen = 1'b0; m1_req = 1'b0; m1_wen = 1'b0;
    endtask

    initial begin
        int n0, n1, first1, solo, wait1;
        logic acc0, acc1;

        rst = 1'b1;
        idle_inputs();
        m0_addr = '0; m0_wdata = '0; m1_addr = '0; m1_wdata = '0;
        bus_rdata = 32'h5555_AAAA;
        model_step();
        @(posedge clk);
        #1;
        do_reset();

        // Idle after reset
        repeat (5) begin
            sample();
            chk("idle_owner", owner, 2'b00);
            chk("idle_bus_wen", bus_wen, 1'b0);
            chk("idle_bus_addr", bus_addr, 32'h0);
            chk("idle_m0_rdata", m0_rdata, 32'hFFFF_FFFF);
            chk("idle_m1_rdata", m1_rdata, 32'hFFFF_FFFF);
            advance();
        end

        // Single m0 write
        m0_req = 1'b1; m0_addr = 32'h100; m0_wen = 1'b1; m0_wdata = 32'hDEAD_BEEF;
        sample();
        chk("wr_c1_m0_gnt", m0_gnt, 1'b0);
        advance();
        sample();
        chk("wr_c2_m0_gnt", m0_gnt, 1'b1);
        chk("wr_c2_bus_wen", bus_wen, 1'b1);
        chk("wr_c2_bus_addr", bus_addr, 32'h100);
        chk("wr_c2_bus_wdata", bus_wdata, 32'hDEAD_BEEF);
        chk("wr_c2_m1_gnt", m1_gnt, 1'b0);
        advance();
        m0_req = 1'b0;
        sample();
        chk("wr_c3_bus_wen", bus_wen, 1'b0);
        advance();
        sample();
        chk("wr_c4_owner", owner, 2'b00);
        advance();
        m0_wen = 1'b0;

        // Contested bursts from reset
        do_reset();
        m0_req = 1'b1; m0_addr = 32'h1000; m1_req = 1'b1; m1_addr = 32'h2000;
        n0 = 0; n1 = 0; first1 = -1;
        for (int i = 0; i < 20; i++) begin
            sample();
            if (i <= 16 && m0_gnt === 1'b1) n0++;
            if (i <= 16 && m1_gnt === 1'b1) n1++;
            if (first1 < 0 && m1_gnt === 1'b1) first1 = i;
            advance();
        end
        chk("burst_m0_count", n0, 8);
        chk("burst_m1_count", n1, 8);
        chk("burst_m1_first", first1, 9);
        idle_inputs();
        cycle(); cycle();

        // m1 owns; m0 write enable without request must not reach the bus
        m1_req = 1'b1; m1_addr = 32'hFFFF_F000; m1_wen = 1'b0;
        m0_req = 1'b0; m0_wen = 1'b1; m0_addr = 32'hAAAA_0000;
        bus_rdata = 32'h12;
        cycle();
        sample();
        chk("rd_m1_gnt", m1_gnt, 1'b1);
        chk("rd_m1_rdata", m1_rdata, 32'h12);
        chk("rd_m0_rdata", m0_rdata, 32'hFFFF_FFFF);
        chk("rd_bus_wen", bus_wen, 1'b0);
        chk("rd_bus_addr", bus_addr, 32'hFFFF_F000);
        advance();
        m1_wen = 1'b1; m1_wdata = 32'h77;
        sample();
        chk("m1wr_bus_wen", bus_wen, 1'b1);
        chk("m1wr_bus_wdata", bus_wdata, 32'h77);
        advance();
        idle_inputs();
        cycle(); cycle();

        // Reset mid-burst with a write pending
        do_reset();
        m0_req = 1'b1; m0_wen = 1'b1; m0_addr = 32'h200; m0_wdata = 32'hCAFE;
        m1_req = 1'b1; m1_addr = 32'h300;
        repeat (4) cycle();
        rst = 1'b1;
        sample();
        chk("rstmid_m0_gnt", m0_gnt, 1'b1);
        chk("rstmid_bus_wen", bus_wen, 1'b0);
        advance();
        rst = 1'b0;
        sample();
        chk("rstmid_owner_after", owner, 2'b00);
        advance();
        sample();
        chk("rstmid_regrant", m0_gnt, 1'b1);
        advance();
        idle_inputs();
        cycle(); cycle();

        // Lone m0 is never cut off; m1 then waits a bounded time
        do_reset();
        m0_req = 1'b1; m0_addr = 32'h400; m0_wen = 1'b0;
        cycle();
        solo = 0;
        for (int i = 0; i < 20; i++) begin
            sample();
            if (m0_gnt === 1'b1) solo++;
            advance();
        end
        chk("solo_continuous", solo, 20);
        m1_req = 1'b1; m1_addr = 32'h500;
        wait1 = -1;
        for (int i = 0; i < 12; i++) begin
            sample();
            if (wait1 < 0 && m1_gnt === 1'b1) wait1 = i;
            advance();
        end
        chk("m1_wait_cycles", wait1, 8);
        idle_inputs();
        cycle(); cycle();

        // Randomized traffic; a waiting master holds its request stable
        for (int n = 0; n < 2000; n++) begin
            sample();
            acc0 = (m_own == 0) && m0_req;
            acc1 = (m_own == 1) && m1_req;
            advance();
            rst = ($urandom_range(0, 63) == 0);
            bus_rdata = $urandom;
            if (!(m0_req && !acc0)) begin
                m0_req   = ($urandom_range(0, 2) != 0);
                m0_addr  = $urandom;
                m0_wen   = $urandom_range(0, 1);
                m0_wdata = $urandom;
            end
            if (!(m1_req && !acc1)) begin
                m1_req   = ($urandom_range(0, 2) != 0);
                m1_addr  = $urandom;
                m1_wen   = $urandom_range(0, 1);
                m1_wdata = $urandom;
            end
        end
        rst = 1'b0;
        cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
